// File: rtl/mul_float_share_arb.sv
// Round-robin front end sharing one 2-stage mul_float_cal between PL_REQ_N requesters.
// Issued requester IDs are queued in a tag FIFO so each result handshake returns to its owner.
module mul_float_share_arb #(
    parameter int PL_REQ_N     = 4,
    parameter int PL_TAG_DEPTH = 4,
    parameter int PL_ID_W      = $clog2(PL_REQ_N)
) (
    input  logic                          iCLOCK,
    input  logic                          inRESET,
    input  logic                          iRESET_SYNC,
    input  logic [PL_REQ_N-1:0]           iREQ_VALID,
    output logic [PL_REQ_N-1:0]           oREQ_BUSY,
    input  logic [32*PL_REQ_N-1:0]        iREQ_DATA_A,
    input  logic [32*PL_REQ_N-1:0]        iREQ_DATA_B,
    output logic                          oMUL_REQ,
    input  logic                          iMUL_BUSY,
    output logic [31:0]                   oMUL_DATA_A,
    output logic [31:0]                   oMUL_DATA_B,
    input  logic                          iMUL_VALID,
    output logic                          oMUL_BUSY,
    output logic [PL_REQ_N-1:0]           oRESP_VALID,
    output logic [PL_ID_W-1:0]            oRESP_ID,
    input  logic [PL_REQ_N-1:0]           iRESP_BUSY,
    output logic [$clog2(PL_TAG_DEPTH):0] oINFLIGHT,
    output logic                          oERR_UNDERFLOW
);
    localparam int PTR_W = $clog2(PL_TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int unsigned REQ_N = PL_REQ_N;
    localparam logic [PL_ID_W-1:0] LAST_ID = PL_ID_W'(PL_REQ_N - 1);
    localparam logic [CNT_W-1:0]   DEPTH   = CNT_W'(PL_TAG_DEPTH);

    logic [PL_ID_W-1:0] b_last;
    logic [PL_ID_W-1:0] grant;
    logic [PL_ID_W-1:0] cand;
    logic               grant_valid;
    logic               issue;
    logic               full;
    logic               empty;
    logic               resp_live;
    logic               pop;
    logic [PL_ID_W-1:0] head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               err_underflow;
    logic [PL_ID_W-1:0] tag_mem [PL_TAG_DEPTH];

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= REQ_N; k++) begin
            cand = PL_ID_W'((32'(b_last) + k) % REQ_N);
            if (!grant_valid && iREQ_VALID[cand]) begin
                grant_valid = 1'b1;
                grant       = cand;
            end
        end
    end

    assign full     = (count == DEPTH);
    assign empty    = (count == '0);
    assign oMUL_REQ = grant_valid && !full;
    assign issue    = oMUL_REQ && !iMUL_BUSY;

    always_comb begin
        oMUL_DATA_A = '0;
        oMUL_DATA_B = '0;
        oREQ_BUSY   = '1;
        for (int unsigned i = 0; i < REQ_N; i++) begin
            if (grant_valid && grant == PL_ID_W'(i)) begin
                oMUL_DATA_A = iREQ_DATA_A[i*32 +: 32];
                oMUL_DATA_B = iREQ_DATA_B[i*32 +: 32];
                oREQ_BUSY[i] = !issue;
            end
        end
    end

    assign head        = tag_mem[rd_ptr];
    assign resp_live   = iMUL_VALID && !empty;
    assign oMUL_BUSY   = resp_live && iRESP_BUSY[head];
    assign pop         = resp_live && !iRESP_BUSY[head];
    assign oRESP_VALID = resp_live ? (PL_REQ_N'(1) << head) : '0;
    assign oRESP_ID    = head;
    assign oINFLIGHT   = count;
    assign oERR_UNDERFLOW = err_underflow;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            b_last        <= LAST_ID;
            err_underflow <= 1'b0;
        end else if (iRESET_SYNC) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            b_last        <= LAST_ID;
            err_underflow <= 1'b0;
        end else begin
            if (issue) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                b_last <= grant;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (issue && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!issue && pop) begin
                count <= count - CNT_W'(1);
            end
            if (iMUL_VALID && empty) begin
                err_underflow <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: entries are only read behind a non-zero count.
    always_ff @(posedge iCLOCK) begin
        if (issue) begin
            tag_mem[wr_ptr] <= grant;
        end
    end

endmodule

// File: tb/tb_mul_float_share_arb.sv
// Directed bench for mul_float_share_arb with a behavioural 2-stage multiplier handshake model.
module tb_mul_float_share_arb;
    localparam int N = 4;

    logic            iCLOCK = 1'b0;
    logic            inRESET = 1'b0;
    logic            iRESET_SYNC = 1'b0;
    logic [N-1:0]    iREQ_VALID = '0;
    logic [N-1:0]    oREQ_BUSY;
    logic [32*N-1:0] iREQ_DATA_A;
    logic [32*N-1:0] iREQ_DATA_B;
    logic            oMUL_REQ;
    logic            iMUL_BUSY;
    logic [31:0]     oMUL_DATA_A;
    logic [31:0]     oMUL_DATA_B;
    logic            iMUL_VALID;
    logic            oMUL_BUSY;
    logic [N-1:0]    oRESP_VALID;
    logic [1:0]      oRESP_ID;
    logic [N-1:0]    iRESP_BUSY = '0;
    logic [2:0]      oINFLIGHT;
    logic            oERR_UNDERFLOW;

    logic            manual = 1'b0;
    logic            man_valid = 1'b0;
    logic            man_busy = 1'b0;
    logic            v1, v2;
    logic [31:0]     a_of [N];
    int              compared = 0;
    int              mismatched = 0;

    mul_float_share_arb #(.PL_REQ_N(N), .PL_TAG_DEPTH(4)) dut (
        .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
        .iREQ_VALID(iREQ_VALID), .oREQ_BUSY(oREQ_BUSY),
        .iREQ_DATA_A(iREQ_DATA_A), .iREQ_DATA_B(iREQ_DATA_B),
        .oMUL_REQ(oMUL_REQ), .iMUL_BUSY(iMUL_BUSY),
        .oMUL_DATA_A(oMUL_DATA_A), .oMUL_DATA_B(oMUL_DATA_B),
        .iMUL_VALID(iMUL_VALID), .oMUL_BUSY(oMUL_BUSY),
        .oRESP_VALID(oRESP_VALID), .oRESP_ID(oRESP_ID), .iRESP_BUSY(iRESP_BUSY),
        .oINFLIGHT(oINFLIGHT), .oERR_UNDERFLOW(oERR_UNDERFLOW)
    );

    always #5 iCLOCK = ~iCLOCK;

    // Multiplier model: valid bits only, whole pipeline stalls on its output busy.
    assign iMUL_VALID = manual ? man_valid : v2;
    assign iMUL_BUSY  = manual ? man_busy  : oMUL_BUSY;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else if (iRESET_SYNC) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else if (!manual && !oMUL_BUSY) begin
            v2 <= v1;
            v1 <= oMUL_REQ && !iMUL_BUSY;
        end
    end

    task automatic tick;
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic test_reset;
        tick;
        tick;
        #1;
        compared++; if (oINFLIGHT !== 3'd0) begin mismatched++; $display("FAIL reset_inflight: got %0d expected 0", oINFLIGHT); end
        compared++; if (oRESP_VALID !== 4'h0) begin mismatched++; $display("FAIL reset_resp_valid: got %b expected 0000", oRESP_VALID); end
        compared++; if (oMUL_BUSY !== 1'b0) begin mismatched++; $display("FAIL reset_mul_busy: got %b expected 0", oMUL_BUSY); end
        compared++; if (oERR_UNDERFLOW !== 1'b0) begin mismatched++; $display("FAIL reset_underflow: got %b expected 0", oERR_UNDERFLOW); end
        compared++; if (oMUL_REQ !== 1'b0) begin mismatched++; $display("FAIL reset_mul_req: got %b expected 0", oMUL_REQ); end
        compared++; if (oREQ_BUSY !== 4'hF) begin mismatched++; $display("FAIL reset_req_busy: got %b expected 1111", oREQ_BUSY); end
        inRESET = 1'b1;
        tick;
    endtask

    task automatic test_single;
        iREQ_VALID = 4'b0100;
        #1;
        compared++; if (oMUL_REQ !== 1'b1) begin mismatched++; $display("FAIL single_mul_req: got %b expected 1", oMUL_REQ); end
        compared++; if (oREQ_BUSY !== 4'b1011) begin mismatched++; $display("FAIL single_req_busy: got %b expected 1011", oREQ_BUSY); end
        compared++; if (oMUL_DATA_A !== 32'h40000000) begin mismatched++; $display("FAIL single_data_a: got %h expected 40000000", oMUL_DATA_A); end
        compared++; if (oMUL_DATA_B !== 32'h40400000) begin mismatched++; $display("FAIL single_data_b: got %h expected 40400000", oMUL_DATA_B); end
        tick;
        iREQ_VALID = 4'b0000;
        #1;
        compared++; if (oMUL_DATA_A !== 32'h0) begin mismatched++; $display("FAIL single_data_idle: got %h expected 0", oMUL_DATA_A); end
        compared++; if (oINFLIGHT !== 3'd1) begin mismatched++; $display("FAIL single_inflight1: got %0d expected 1", oINFLIGHT); end
        compared++; if (oRESP_VALID !== 4'h0) begin mismatched++; $display("FAIL single_resp_early: got %b expected 0000", oRESP_VALID); end
        tick;
        #1;
        compared++; if (oRESP_VALID !== 4'b0100) begin mismatched++; $display("FAIL single_resp_valid: got %b expected 0100", oRESP_VALID); end
        compared++; if (oRESP_ID !== 2'd2) begin mismatched++; $display("FAIL single_resp_id: got %0d expected 2", oRESP_ID); end
        tick;
        #1;
        compared++; if (oINFLIGHT !== 3'd0) begin mismatched++; $display("FAIL single_inflight0: got %0d expected 0", oINFLIGHT); end
        compared++; if (oRESP_VALID !== 4'h0) begin mismatched++; $display("FAIL single_resp_done: got %b expected 0000", oRESP_VALID); end
    endtask

    task automatic test_round_robin;
        logic [3:0] e;
        iRESET_SYNC = 1'b1;
        tick;
        iRESET_SYNC = 1'b0;
        for (int k = 0; k < 10; k++) begin
            iREQ_VALID = (k < 8) ? 4'hF : 4'h0;
            #1;
            if (k < 8) begin
                e = ~4'(1 << (k % 4));
                compared++; if (oREQ_BUSY !== e) begin mismatched++; $display("FAIL rr_grant c%0d: got busy %b expected %b", k, oREQ_BUSY, e); end
                compared++; if (oMUL_DATA_A !== a_of[k % 4]) begin mismatched++; $display("FAIL rr_data c%0d: got %h expected %h", k, oMUL_DATA_A, a_of[k % 4]); end
            end
            e = (k >= 2) ? 4'(1 << ((k - 2) % 4)) : 4'h0;
            compared++; if (oRESP_VALID !== e) begin mismatched++; $display("FAIL rr_resp c%0d: got %b expected %b", k, oRESP_VALID, e); end
            if (k >= 2) begin
                compared++; if (oRESP_ID !== 2'((k - 2) % 4)) begin mismatched++; $display("FAIL rr_resp_id c%0d: got %0d expected %0d", k, oRESP_ID, (k - 2) % 4); end
            end
            tick;
        end
        #1;
        compared++; if (oINFLIGHT !== 3'd0) begin mismatched++; $display("FAIL rr_drained: got %0d expected 0", oINFLIGHT); end
    endtask

    task automatic test_backpressure;
        logic [3:0] exp_resp [8] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h0};
        logic       exp_mb   [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [2:0] exp_inf  [8] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd1, 3'd0};
        for (int k = 0; k < 8; k++) begin
            iREQ_VALID = (k == 0) ? 4'b0011 : (k == 1) ? 4'b0010 : 4'b0000;
            iRESP_BUSY = (k >= 2 && k <= 4) ? 4'b0001 : 4'b0000;
            #1;
            if (k == 0) begin
                compared++; if (oREQ_BUSY !== 4'b1110) begin mismatched++; $display("FAIL bp_grant0: got %b expected 1110", oREQ_BUSY); end
            end
            if (k == 1) begin
                compared++; if (oREQ_BUSY !== 4'b1101) begin mismatched++; $display("FAIL bp_grant1: got %b expected 1101", oREQ_BUSY); end
            end
            compared++; if (oRESP_VALID !== exp_resp[k]) begin mismatched++; $display("FAIL bp_resp c%0d: got %b expected %b", k, oRESP_VALID, exp_resp[k]); end
            compared++; if (oMUL_BUSY !== exp_mb[k]) begin mismatched++; $display("FAIL bp_mul_busy c%0d: got %b expected %b", k, oMUL_BUSY, exp_mb[k]); end
            compared++; if (oINFLIGHT !== exp_inf[k]) begin mismatched++; $display("FAIL bp_inflight c%0d: got %0d expected %0d", k, oINFLIGHT, exp_inf[k]); end
            tick;
        end
        iRESP_BUSY = 4'h0;
    endtask

    task automatic test_fifo_full;
        logic [3:0] e;
        manual     = 1'b1;
        man_valid  = 1'b0;
        man_busy   = 1'b0;
        iRESP_BUSY = 4'hF;
        iREQ_VALID = 4'hF;
        for (int k = 0; k < 4; k++) begin
            #1;
            e = ~4'(1 << ((k + 2) % 4));
            compared++; if (oREQ_BUSY !== e) begin mismatched++; $display("FAIL full_grant c%0d: got %b expected %b", k, oREQ_BUSY, e); end
            compared++; if (oINFLIGHT !== 3'(k)) begin mismatched++; $display("FAIL full_fill c%0d: got %0d expected %0d", k, oINFLIGHT, k); end
            tick;
        end
        man_valid = 1'b1;
        #1;
        compared++; if (oINFLIGHT !== 3'd4) begin mismatched++; $display("FAIL full_count: got %0d expected 4", oINFLIGHT); end
        compared++; if (oMUL_REQ !== 1'b0) begin mismatched++; $display("FAIL full_mul_req: got %b expected 0", oMUL_REQ); end
        compared++; if (oREQ_BUSY !== 4'hF) begin mismatched++; $display("FAIL full_req_busy: got %b expected 1111", oREQ_BUSY); end
        compared++; if (oMUL_BUSY !== 1'b1) begin mismatched++; $display("FAIL full_mul_busy: got %b expected 1", oMUL_BUSY); end
        compared++; if (oRESP_VALID !== 4'b0100) begin mismatched++; $display("FAIL full_head_held: got %b expected 0100", oRESP_VALID); end
        tick;
        iRESP_BUSY = 4'h0;
        #1;
        compared++; if (oMUL_REQ !== 1'b0) begin mismatched++; $display("FAIL full_pop_no_push: got %b expected 0", oMUL_REQ); end
        compared++; if (oRESP_VALID !== 4'b0100) begin mismatched++; $display("FAIL full_drain2: got %b expected 0100", oRESP_VALID); end
        compared++; if (oMUL_BUSY !== 1'b0) begin mismatched++; $display("FAIL full_release: got %b expected 0", oMUL_BUSY); end
        tick;
        iREQ_VALID = 4'h0;
        for (int k = 6; k < 9; k++) begin
            #1;
            e = 4'(1 << ((k - 3) % 4));
            compared++; if (oRESP_VALID !== e) begin mismatched++; $display("FAIL full_drain c%0d: got %b expected %b", k, oRESP_VALID, e); end
            compared++; if (oINFLIGHT !== 3'(9 - k)) begin mismatched++; $display("FAIL full_drain_count c%0d: got %0d expected %0d", k, oINFLIGHT, 9 - k); end
            tick;
        end
        man_valid = 1'b0;
        #1;
        compared++; if (oINFLIGHT !== 3'd0) begin mismatched++; $display("FAIL full_empty: got %0d expected 0", oINFLIGHT); end
        manual = 1'b0;
    endtask

    task automatic test_reset_mid(input bit use_async);
        iREQ_VALID = 4'b1000;
        #1;
        compared++; if (oREQ_BUSY !== 4'b0111) begin mismatched++; $display("FAIL mid_issue_a async=%0d: got %b expected 0111", use_async, oREQ_BUSY); end
        tick;
        iREQ_VALID = 4'b0100;
        #1;
        compared++; if (oREQ_BUSY !== 4'b1011) begin mismatched++; $display("FAIL mid_issue_b async=%0d: got %b expected 1011", use_async, oREQ_BUSY); end
        tick;
        iREQ_VALID = 4'b0000;
        if (use_async) begin
            inRESET = 1'b0;
            #1;
            compared++; if (oINFLIGHT !== 3'd0) begin mismatched++; $display("FAIL mid_async_clear: got %0d expected 0", oINFLIGHT); end
            compared++; if (oRESP_VALID !== 4'h0) begin mismatched++; $display("FAIL mid_async_resp: got %b expected 0000", oRESP_VALID); end
            compared++; if (oMUL_BUSY !== 1'b0) begin mismatched++; $display("FAIL mid_async_mul_busy: got %b expected 0", oMUL_BUSY); end
            tick;
            inRESET = 1'b1;
        end else begin
            iRESET_SYNC = 1'b1;
            tick;
            iRESET_SYNC = 1'b0;
        end
        iREQ_VALID = 4'b1001;
        #1;
        compared++; if (oINFLIGHT !== 3'd0) begin mismatched++; $display("FAIL mid_inflight async=%0d: got %0d expected 0", use_async, oINFLIGHT); end
        compared++; if (oRESP_VALID !== 4'h0) begin mismatched++; $display("FAIL mid_no_resp async=%0d: got %b expected 0000", use_async, oRESP_VALID); end
        compared++; if (oREQ_BUSY !== 4'b1110) begin mismatched++; $display("FAIL mid_next_grant async=%0d: got %b expected 1110", use_async, oREQ_BUSY); end
        tick;
        iREQ_VALID = 4'b0000;
        #1;
        compared++; if (oRESP_VALID !== 4'h0) begin mismatched++; $display("FAIL mid_dropped async=%0d: got %b expected 0000", use_async, oRESP_VALID); end
        compared++; if (oINFLIGHT !== 3'd1) begin mismatched++; $display("FAIL mid_reissue async=%0d: got %0d expected 1", use_async, oINFLIGHT); end
        tick;
        #1;
        compared++; if (oRESP_VALID !== 4'b0001) begin mismatched++; $display("FAIL mid_resp0 async=%0d: got %b expected 0001", use_async, oRESP_VALID); end
        tick;
        #1;
        compared++; if (oINFLIGHT !== 3'd0) begin mismatched++; $display("FAIL mid_final async=%0d: got %0d expected 0", use_async, oINFLIGHT); end
    endtask

    task automatic test_underflow;
        manual     = 1'b1;
        man_valid  = 1'b1;
        man_busy   = 1'b0;
        iRESP_BUSY = 4'hF;
        #1;
        compared++; if (oERR_UNDERFLOW !== 1'b0) begin mismatched++; $display("FAIL uf_initial: got %b expected 0", oERR_UNDERFLOW); end
        compared++; if (oRESP_VALID !== 4'h0) begin mismatched++; $display("FAIL uf_resp: got %b expected 0000", oRESP_VALID); end
        compared++; if (oMUL_BUSY !== 1'b0) begin mismatched++; $display("FAIL uf_mul_busy: got %b expected 0", oMUL_BUSY); end
        tick;
        man_valid = 1'b0;
        #1;
        compared++; if (oERR_UNDERFLOW !== 1'b1) begin mismatched++; $display("FAIL uf_set: got %b expected 1", oERR_UNDERFLOW); end
        tick;
        tick;
        compared++; if (oERR_UNDERFLOW !== 1'b1) begin mismatched++; $display("FAIL uf_sticky: got %b expected 1", oERR_UNDERFLOW); end
        iRESET_SYNC = 1'b1;
        tick;
        iRESET_SYNC = 1'b0;
        #1;
        compared++; if (oERR_UNDERFLOW !== 1'b0) begin mismatched++; $display("FAIL uf_cleared: got %b expected 0", oERR_UNDERFLOW); end
        manual     = 1'b0;
        iRESP_BUSY = 4'h0;
    endtask

    initial begin
        a_of[0] = 32'hA000_0000;
        a_of[1] = 32'hA000_0001;
        a_of[2] = 32'h4000_0000;
        a_of[3] = 32'hA000_0003;
        for (int i = 0; i < N; i++) begin
            iREQ_DATA_A[i*32 +: 32] = a_of[i];
            iREQ_DATA_B[i*32 +: 32] = 32'hB000_0000 | 32'(i);
        end
        iREQ_DATA_B[2*32 +: 32] = 32'h4040_0000;

        test_reset;
        test_single;
        test_round_robin;
        test_backpressure;
        test_fifo_full;
        test_reset_mid(1'b0);
        test_reset_mid(1'b1);
        test_underflow;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
